// File: rtl/alu_byte_sequencer.sv
// Byte-stream front end for the tp1 ALU: collects operand A, operand B and opcode bytes,
// holds them on the ALU inputs, then offers the registered result on a valid/ready byte port.
module alu_byte_sequencer #(
    parameter int unsigned LEN_DATO = 8,
    parameter int unsigned LEN_OP   = 6
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic [7:0]          i_rx_data,
    input  logic                i_rx_valid,
    output logic [LEN_DATO-1:0] o_dato_a,
    output logic [LEN_DATO-1:0] o_dato_b,
    output logic [LEN_OP-1:0]   o_op_code,
    input  logic [LEN_DATO-1:0] i_resultado,
    output logic [7:0]          o_tx_data,
    input  logic                i_tx_ready,
    output logic                o_tx_valid,
    output logic                o_busy,
    output logic                o_err
);

    localparam logic [LEN_OP-1:0] OP_ADD = LEN_OP'(6'b100000);
    localparam logic [LEN_OP-1:0] OP_SUB = LEN_OP'(6'b100010);
    localparam logic [LEN_OP-1:0] OP_AND = LEN_OP'(6'b100100);
    localparam logic [LEN_OP-1:0] OP_OR  = LEN_OP'(6'b100101);
    localparam logic [LEN_OP-1:0] OP_XOR = LEN_OP'(6'b100110);
    localparam logic [LEN_OP-1:0] OP_NOR = LEN_OP'(6'b100111);
    localparam logic [LEN_OP-1:0] OP_SRA = LEN_OP'(6'b000011);
    localparam logic [LEN_OP-1:0] OP_SRL = LEN_OP'(6'b000010);

    typedef enum logic [2:0] {
        S_A,
        S_B,
        S_OP,
        S_CALC,
        S_SEND
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [LEN_DATO-1:0]   r_dato_a;
    logic [LEN_DATO-1:0]   w_dato_a_next;
    logic [LEN_DATO-1:0]   r_dato_b;
    logic [LEN_DATO-1:0]   w_dato_b_next;
    logic [LEN_OP-1:0]     r_op_code;
    logic [LEN_OP-1:0]     w_op_code_next;
    logic [7:0]            r_tx_data;
    logic [7:0]            w_tx_data_next;
    logic                  r_tx_valid;
    logic                  w_tx_valid_next;
    logic                  r_busy;
    logic                  w_busy_next;
    logic                  r_err;
    logic                  w_err_next;
    logic [LEN_OP-1:0]     w_rx_op;
    logic                  w_op_legal;

    // Opcode legality check on the incoming byte
    always_comb begin
        w_rx_op    = i_rx_data[LEN_OP-1:0];
        w_op_legal = 1'b0;
        case (w_rx_op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_NOR, OP_SRA, OP_SRL: w_op_legal = 1'b1;
            default:                        w_op_legal = 1'b0;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= S_A;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and next register values; bytes arriving in S_CALC/S_SEND fall through untouched
    always_comb begin
        w_state_next    = r_state;
        w_dato_a_next   = r_dato_a;
        w_dato_b_next   = r_dato_b;
        w_op_code_next  = r_op_code;
        w_tx_data_next  = r_tx_data;
        w_tx_valid_next = r_tx_valid;
        w_err_next      = 1'b0;

        case (r_state)
            S_A: begin
                if (i_rx_valid) begin
                    w_dato_a_next = i_rx_data[LEN_DATO-1:0];
                    w_state_next  = S_B;
                end
            end
            S_B: begin
                if (i_rx_valid) begin
                    w_dato_b_next = i_rx_data[LEN_DATO-1:0];
                    w_state_next  = S_OP;
                end
            end
            S_OP: begin
                if (i_rx_valid) begin
                    if (w_op_legal) begin
                        w_op_code_next = w_rx_op;
                        w_state_next   = S_CALC;
                    end else begin
                        w_err_next = 1'b1;
                    end
                end
            end
            S_CALC: begin
                w_tx_data_next  = 8'(i_resultado);
                w_tx_valid_next = 1'b1;
                w_state_next    = S_SEND;
            end
            S_SEND: begin
                if (i_tx_ready) begin
                    w_tx_valid_next = 1'b0;
                    w_state_next    = S_A;
                end
            end
            default: begin
                w_state_next    = S_A;
                w_tx_valid_next = 1'b0;
            end
        endcase

        w_busy_next = (w_state_next == S_CALC) || (w_state_next == S_SEND);
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_dato_a   <= '0;
            r_dato_b   <= '0;
            r_op_code  <= OP_ADD;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_dato_a   <= w_dato_a_next;
            r_dato_b   <= w_dato_b_next;
            r_op_code  <= w_op_code_next;
            r_tx_data  <= w_tx_data_next;
            r_tx_valid <= w_tx_valid_next;
            r_busy     <= w_busy_next;
            r_err      <= w_err_next;
        end
    end

    assign o_dato_a   = r_dato_a;
    assign o_dato_b   = r_dato_b;
    assign o_op_code  = r_op_code;
    assign o_tx_data  = r_tx_data;
    assign o_tx_valid = r_tx_valid;
    assign o_busy     = r_busy;
    assign o_err      = r_err;

endmodule

// File: tb/tb_alu_byte_sequencer.sv
// Self-checking bench for alu_byte_sequencer with a behavioural stand-in for the tp1 ALU
// and a result scoreboard filled when opcodes are sent and drained at each tx handshake.
module tb_alu_byte_sequencer;

    logic       clk;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] dato_a;
    logic [7:0] dato_b;
    logic [5:0] op_code;
    logic [7:0] resultado;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       tx_valid;
    logic       busy;
    logic       err;

    int         errors;
    int         checks;
    logic [7:0] exp_q[$];

    alu_byte_sequencer #(
        .LEN_DATO(8),
        .LEN_OP  (6)
    ) dut (
        .i_clock    (clk),
        .i_reset    (rst_n),
        .i_rx_data  (rx_data),
        .i_rx_valid (rx_valid),
        .o_dato_a   (dato_a),
        .o_dato_b   (dato_b),
        .o_op_code  (op_code),
        .i_resultado(resultado),
        .o_tx_data  (tx_data),
        .i_tx_ready (tx_ready),
        .o_tx_valid (tx_valid),
        .o_busy     (busy),
        .o_err      (err)
    );

    // Combinational ALU stand-in
    always_comb begin
        case (op_code)
            6'b100000: resultado = dato_a + dato_b;
            6'b100010: resultado = dato_a - dato_b;
            6'b100100: resultado = dato_a & dato_b;
            6'b100101: resultado = dato_a | dato_b;
            6'b100110: resultado = dato_a ^ dato_b;
            6'b100111: resultado = ~(dato_a | dato_b);
            6'b000011: resultado = 8'($unsigned($signed(dato_a) >>> dato_b));
            6'b000010: resultado = dato_a >> dato_b;
            default:   resultado = 8'h00;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    // Waits for a handshake, pops and compares; returns at posedge+1 after the accepting edge
    task automatic wait_handshake(input string name, output int lat);
        bit done;
        done = 1'b0;
        lat  = 0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (tx_valid && tx_ready) begin
                logic [7:0] exp;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s unexpected result: got %02h, scoreboard empty", name, tx_data);
                end else begin
                    exp = exp_q.pop_front();
                    if (tx_data !== exp) begin
                        errors++;
                        $display("FAIL %s result: got %02h expected %02h", name, tx_data, exp);
                    end
                end
                @(posedge clk);
                #1;
                done = 1'b1;
            end else begin
                lat++;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s handshake timeout: got none expected one within 50 cycles", name);
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        #12;
        checks++;
        if ({dato_a, dato_b, op_code, tx_data, tx_valid, busy, err} !== {8'h00, 8'h00, 6'h20, 8'h00, 3'b000}) begin
            errors++;
            $display("FAIL reset_values: got a=%02h b=%02h op=%02h tx=%02h v=%b busy=%b err=%b expected 00 00 20 00 0 0 0",
                     dato_a, dato_b, op_code, tx_data, tx_valid, busy, err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_add();
        int lat;
        send_byte(8'h05);
        send_byte(8'h03);
        exp_q.push_back(8'h08);
        send_byte(8'h20);
        checks++;
        if ({dato_a, dato_b, op_code} !== {8'h05, 8'h03, 6'h20}) begin
            errors++;
            $display("FAIL add_operands: got %02h %02h %02h expected 05 03 20", dato_a, dato_b, op_code);
        end
        checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL add_calc_cycle: got valid=%b busy=%b expected valid=0 busy=1", tx_valid, busy);
        end
        wait_handshake("add", lat);
        checks++;
        if (lat != 1) begin
            errors++;
            $display("FAIL add_latency: got %0d expected 1", lat);
        end
        checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL add_valid_width: got valid=%b busy=%b expected 0 0", tx_valid, busy);
        end
    endtask

    task automatic test_sub_sra();
        int lat;
        send_byte(8'h03);
        send_byte(8'h05);
        exp_q.push_back(8'hFE);
        send_byte(8'h22);
        wait_handshake("sub", lat);
        send_byte(8'hA0);
        send_byte(8'h02);
        exp_q.push_back(8'hE8);
        send_byte(8'h03);
        checks++;
        if ({dato_a, dato_b, op_code} !== {8'hA0, 8'h02, 6'h03}) begin
            errors++;
            $display("FAIL sra_operands: got %02h %02h %02h expected a0 02 03", dato_a, dato_b, op_code);
        end
        wait_handshake("sra", lat);
    endtask

    task automatic test_illegal_op();
        int lat;
        send_byte(8'h0F);
        send_byte(8'hF0);
        send_byte(8'h3F);
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || op_code !== 6'h03) begin
            errors++;
            $display("FAIL illegal_err: got err=%b busy=%b op=%02h expected 1 0 03", err, busy, op_code);
        end
        @(posedge clk);
        #1;
        checks++;
        if (err !== 1'b0 || tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL illegal_pulse: got err=%b valid=%b expected 0 0", err, tx_valid);
        end
        exp_q.push_back(8'h00);
        send_byte(8'h24);
        wait_handshake("illegal_then_and", lat);
        send_byte(8'h0F);
        send_byte(8'hF0);
        exp_q.push_back(8'hFF);
        send_byte(8'h25);
        wait_handshake("or", lat);
    endtask

    task automatic test_backpressure();
        int lat;
        int bad;
        tx_ready = 1'b0;
        send_byte(8'h08);
        send_byte(8'h10);
        exp_q.push_back(8'hE7);
        send_byte(8'h27);
        @(posedge clk);
        #1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (tx_valid !== 1'b1 || tx_data !== 8'hE7 || busy !== 1'b1) bad++;
            rx_valid = (i == 1) || (i == 2);
            rx_data  = (i == 1) ? 8'h11 : 8'h22;
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL backpressure_hold: got %0d unstable cycles expected 0", bad);
        end
        checks++;
        if ({dato_a, dato_b, tx_valid} !== {8'h08, 8'h10, 1'b1}) begin
            errors++;
            $display("FAIL busy_drop: got a=%02h b=%02h v=%b expected 08 10 1", dato_a, dato_b, tx_valid);
        end
        tx_ready = 1'b1;
        wait_handshake("nor", lat);
        checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_release: got valid=%b busy=%b expected 0 0", tx_valid, busy);
        end
        send_byte(8'h01);
        send_byte(8'h01);
        exp_q.push_back(8'h02);
        send_byte(8'h20);
        wait_handshake("after_backpressure", lat);
    endtask

    task automatic test_reset_mid();
        int lat;
        send_byte(8'h40);
        send_byte(8'h40);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({dato_a, dato_b, op_code, tx_data, tx_valid, busy, err} !== {8'h00, 8'h00, 6'h20, 8'h00, 3'b000}) begin
            errors++;
            $display("FAIL reset_mid: got a=%02h b=%02h op=%02h tx=%02h v=%b busy=%b err=%b expected 00 00 20 00 0 0 0",
                     dato_a, dato_b, op_code, tx_data, tx_valid, busy, err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_byte(8'h01);
        checks++;
        if (dato_a !== 8'h01 || dato_b !== 8'h00) begin
            errors++;
            $display("FAIL reset_first_byte: got a=%02h b=%02h expected 01 00", dato_a, dato_b);
        end
        send_byte(8'h02);
        exp_q.push_back(8'h03);
        send_byte(8'h20);
        wait_handshake("after_reset", lat);
    endtask

    task automatic test_reset_send();
        int lat;
        int seen;
        tx_ready = 1'b0;
        send_byte(8'h01);
        send_byte(8'h01);
        send_byte(8'h20);
        @(posedge clk);
        #1;
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h02) begin
            errors++;
            $display("FAIL send_pending: got valid=%b data=%02h expected 1 02", tx_valid, tx_data);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b0 || tx_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_in_send: got valid=%b busy=%b data=%02h expected 0 0 00", tx_valid, busy, tx_data);
        end
        @(negedge clk);
        rst_n    = 1'b1;
        tx_ready = 1'b1;
        seen     = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (tx_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL discarded_result: got %0d valid cycles expected 0", seen);
        end
        send_byte(8'h02);
        send_byte(8'h03);
        exp_q.push_back(8'h05);
        send_byte(8'h20);
        wait_handshake("after_send_reset", lat);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_add();
        test_sub_sra();
        test_illegal_op();
        test_backpressure();
        test_reset_mid();
        test_reset_send();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_byte_sequencer.md
Name: alu_byte_sequencer

Overview:
- Sits between a byte-stream source (e.g. UART RX) and the combinational ALU `tp1`.
- Collects three consecutive bytes: operand A, operand B, opcode. Drives them onto the ALU inputs.
- Registers the ALU result one cycle later, then offers it downstream on a valid/ready byte interface (e.g. UART TX).
- Single clock domain; the ALU is instantiated alongside it, not inside it.

Parameters:
- LEN_DATO, 8, operand/result width (bits); must be ≤ 8 since bytes carry operands.
- LEN_OP, 6, opcode width; taken from the low LEN_OP bits of the opcode byte.

Ports:
- i_clock  in  1  system clock, rising-edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_rx_data  in  8  incoming byte.
- i_rx_valid  in  1  one-cycle strobe: i_rx_data is valid this cycle (source has no ready).
- o_dato_a  out  LEN_DATO  operand A to ALU, registered.
- o_dato_b  out  LEN_DATO  operand B to ALU, registered.
- o_op_code  out  LEN_OP  opcode to ALU, registered.
- i_resultado  in  LEN_DATO  ALU result (combinational from o_dato_a/o_dato_b/o_op_code).
- o_tx_data  out  8  result byte, zero-extended if LEN_DATO<8.
- i_tx_ready  in  1  downstream accepts o_tx_data when o_tx_valid && i_tx_ready.
- o_tx_valid  out  1  o_tx_data valid.
- o_busy  out  1  high in S_CALC and S_SEND (incoming bytes are dropped).
- o_err  out  1  one-cycle pulse on an illegal opcode byte.

Behaviour:
- Reset (i_reset=0, async):
  - state=S_A.
  - o_dato_a=0, o_dato_b=0, o_op_code=6'b100000 (ADD).
  - o_tx_data=0, o_tx_valid=0, o_busy=0, o_err=0.
- FSM states: S_A, S_B, S_OP, S_CALC, S_SEND.
- S_A: on i_rx_valid, o_dato_a<=i_rx_data[LEN_DATO-1:0]; go to S_B.
- S_B: on i_rx_valid, o_dato_b<=i_rx_data[LEN_DATO-1:0]; go to S_OP.
- S_OP: on i_rx_valid, examine op=i_rx_data[LEN_OP-1:0].
  - Legal set: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR, 000011 SRA, 000010 SRL.
  - Legal: o_op_code<=op; go to S_CALC.
  - Illegal: o_op_code unchanged; o_err=1 for exactly one cycle; stay in S_OP.
  - A/B are retained; the next byte is treated as a new opcode.
- S_CALC: exactly one cycle; ALU inputs are stable.
  - o_tx_data<=i_resultado (zero-extended); o_tx_valid<=1; go to S_SEND.
- S_SEND: hold o_tx_data and o_tx_valid=1 stable until the cycle with i_tx_ready=1.
  - On that edge: o_tx_valid<=0; go to S_A.
- Latency:
  - Opcode accepted at edge N.
  - o_tx_valid rises after edge N+1.
  - Earliest handshake at edge N+2 (i_tx_ready held high).
- i_rx_valid while in S_CALC or S_SEND: byte ignored, no state change.
- o_busy=1 exactly in S_CALC and S_SEND.
- i_tx_ready while o_tx_valid=0: ignored.
- o_dato_a/o_dato_b/o_op_code hold their last values until the next byte overwrites them. A new A byte does not clear B or the opcode.
- Reset asserted in any state, including mid-collection or S_SEND: immediate return to reset values. A pending result is discarded (no handshake). After release, the first valid byte is operand A.
- i_rx_valid high for multiple consecutive cycles: each cycle counts as a separate byte.

Test Plan (bench instantiates alu_byte_sequencer + tp1, LEN_DATO=8, LEN_OP=6):
- ADD: bytes 0x05,0x03,0x20, i_tx_ready=1 → o_tx_data=0x08. o_tx_valid rises exactly 1 cycle after the opcode edge and is high for exactly 1 cycle.
- SUB/SRA: 0x03,0x05,0x22 → 0xFE; then 0xA0,0x02,0x03 → 0xE8.
- Illegal opcode: 0x0F,0xF0,0x3F → o_err pulses once, o_tx_valid stays 0. Then 0x24 → o_tx_data=0x00 (AND); then 0x0F,0xF0,0x25 → 0xFF.
- Backpressure: 0x08,0x10,0x27 with i_tx_ready=0 for 5 cycles → o_tx_valid=1 and o_tx_data=0xE7 stable throughout, o_busy=1. Bytes 0x11,0x22 sent meanwhile are dropped. After i_tx_ready=1, next sequence 0x01,0x01,0x20 → 0x02.
- Reset mid-operation: send 0x40,0x40, pulse i_reset low → all outputs at reset values, no o_tx_valid. Then 0x01,0x02,0x20 → 0x03.
- Reset during S_SEND: result pending with i_tx_ready=0, assert reset → o_tx_valid drops immediately (asynchronously), state S_A.
